// File: rtl/btn_conditioner.sv
// Debounced multi-channel button conditioner with press/release pulses and auto-repeat.
// 2-flop sync, then a stable-count debounce; level moves DEBOUNCE_CYCLES+2 edges after a held raw change.
module btn_conditioner #(
  parameter int              N_CH            = 4,
  parameter int              DEBOUNCE_CYCLES = 1000000,
  parameter int              REPEAT_DELAY    = 50000000,
  parameter int              REPEAT_PERIOD   = 10000000,
  parameter logic [N_CH-1:0] ACTIVE_LOW      = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] released,
  output logic [N_CH-1:0] rpt,
  output logic [N_CH-1:0] long_hold,
  output logic            any_press
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX) + 1;

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST   = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [N_CH-1:0] sync1, sync2, sample, rise, fall;

  // Sync flops idle at the released raw level so a held button debounces as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign sample = sync2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_press <= 1'b0;
    else        any_press <= |rise;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic          lvl_q, press_q, rel_q, rpt_q, long_q;
    state_t        state;

    assign rise[i] = !lvl_q && sample[i] && (db_cnt == DB_LAST);
    assign fall[i] = lvl_q && !sample[i] && (db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt  <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= rise[i];
        rel_q   <= fall[i];
        if (sample[i] == lvl_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          lvl_q  <= ~lvl_q;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    // Dropping repeat_en or releasing always wins, so a re-enabled held key stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= IDLE;
        hold_cnt <= '0;
        rpt_q    <= 1'b0;
        long_q   <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        if (fall[i] || !repeat_en[i]) begin
          state    <= IDLE;
          hold_cnt <= '0;
          long_q   <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              hold_cnt <= '0;
              if (rise[i]) state <= DELAY;
            end
            DELAY: begin
              if (hold_cnt == DELAY_LAST) begin
                rpt_q    <= 1'b1;
                long_q   <= 1'b1;
                hold_cnt <= '0;
                state    <= REPEAT;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            REPEAT: begin
              if (hold_cnt == PER_LAST) begin
                rpt_q    <= 1'b1;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end

    assign level[i]     = lvl_q;
    assign press[i]     = press_q;
    assign released[i]  = rel_q;
    assign rpt[i]       = rpt_q;
    assign long_hold[i] = long_q;
  end

endmodule
